// File: rtl/pcm_frame_packer.sv
// pcm_frame_packer: packs PCM strobes into ping-pong BRAM frames behind a big-endian sequence number
module pcm_frame_packer #(
    parameter int NCHAN     = 8,
    parameter int SAMPLES   = 32,
    parameter int HDR_BYTES = 14,
    parameter int OFS_W     = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pcm_stb,
    input  logic [16*NCHAN-1:0] pcm_data,
    output logic                wr_en,
    output logic [OFS_W:0]      wr_addr,
    output logic [7:0]          wr_data,
    output logic                tx_start,
    output logic                tx_bank,
    input  logic                tx_busy,
    output logic [15:0]         drop_count
);
    localparam int CW = (2*NCHAN > 4) ? $clog2(2*NCHAN) : 2;
    localparam int SW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

    typedef enum logic [2:0] {IDLE, SEQ, SAMPLE, WAIT_TX, HOLDOFF} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [SW-1:0]       stb_cnt;
    logic [16*NCHAN-1:0] snap;
    logic [31:0]         seq_num;
    logic [OFS_W-1:0]    samp_ofs;
    logic                last_byte, last_strobe;

    assign last_byte   = cnt == CW'(2*NCHAN-1);
    assign last_strobe = stb_cnt == SW'(SAMPLES-1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Write port is decoded straight from state so it drops to zero the instant reset hits
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        case (state)
            IDLE:    if (pcm_stb) state_nxt = (stb_cnt == '0) ? SEQ : SAMPLE;
            SEQ: begin
                wr_en   = 1'b1;
                wr_addr = {~tx_bank, OFS_W'(HDR_BYTES) + OFS_W'(cnt)};
                wr_data = seq_num[{~cnt[1:0], 3'b000} +: 8];
                if (cnt == CW'(3)) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                wr_en   = 1'b1;
                wr_addr = {~tx_bank, samp_ofs};
                wr_data = snap[{cnt, 3'b000} +: 8];
                if (last_byte) state_nxt = last_strobe ? WAIT_TX : IDLE;
            end
            WAIT_TX: if (!tx_busy) state_nxt = HOLDOFF;
            HOLDOFF: if (cnt == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            stb_cnt    <= '0;
            snap       <= '0;
            seq_num    <= '0;
            samp_ofs   <= OFS_W'(HDR_BYTES+4);
            tx_start   <= 1'b0;
            tx_bank    <= 1'b0;
            drop_count <= '0;
        end else begin
            tx_start <= 1'b0;
            cnt      <= (state_nxt != state) ? '0 : cnt + 1'b1;
            if (state == IDLE && pcm_stb)
                snap <= pcm_data;
            if (state != IDLE && pcm_stb && drop_count != 16'hFFFF)
                drop_count <= drop_count + 1'b1;
            if (state == SAMPLE) begin
                samp_ofs <= samp_ofs + 1'b1;
                if (last_byte) begin
                    stb_cnt <= last_strobe ? '0 : stb_cnt + 1'b1;
                    if (last_strobe) samp_ofs <= OFS_W'(HDR_BYTES+4);
                end
            end
            if (state == WAIT_TX && !tx_busy) begin
                tx_bank  <= ~tx_bank;
                tx_start <= 1'b1;
                seq_num  <= seq_num + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pcm_frame_packer.sv
// tb_pcm_frame_packer: scoreboard bench for the PCM frame packer with NCHAN=2, SAMPLES=2
module tb_pcm_frame_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic        pcm_stb = 1'b0;
    logic [31:0] pcm_data = '0;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        tx_start;
    logic        tx_bank;
    logic        tx_busy = 1'b0;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    int slot = 0;
    int exp_drop = 0;
    logic        exp_tx_bank = 1'b0;
    logic [31:0] exp_seq = '0;
    logic [18:0] wq[$];
    logic        txq[$];
    logic [18:0] mon_exp;
    logic        mon_bank;

    pcm_frame_packer #(.NCHAN(2), .SAMPLES(2), .HDR_BYTES(14), .OFS_W(10)) dut (
        .clk(clk), .rst(rst), .pcm_stb(pcm_stb), .pcm_data(pcm_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tx_start(tx_start), .tx_bank(tx_bank), .tx_busy(tx_busy),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (wr_en) begin
                checks++;
                if (wr_addr[9:0] < 10'd14) begin
                    errors++;
                    $display("FAIL header_write: offset=%0d required>=14", wr_addr[9:0]);
                end
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h data=%h", wr_addr, wr_data);
                end else begin
                    mon_exp = wq.pop_front();
                    if ({wr_addr, wr_data} !== mon_exp) begin
                        errors++;
                        $display("FAIL write: addr=%h data=%h required addr=%h data=%h",
                                 wr_addr, wr_data, mon_exp[18:8], mon_exp[7:0]);
                    end
                end
            end
            if (tx_start) begin
                tx_seen++;
                checks++;
                if (txq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tx_start: tx_bank=%b", tx_bank);
                end else begin
                    mon_bank = txq.pop_front();
                    if (tx_bank !== mon_bank) begin
                        errors++;
                        $display("FAIL tx_bank: got %b required %b", tx_bank, mon_bank);
                    end
                end
            end
        end
    end

    task automatic strobe(input logic [31:0] d, input bit ovr, input logic [31:0] od);
        int n;
        logic fill;
        fill = ~exp_tx_bank;
        n = (slot == 0) ? 8 : 4;
        @(posedge clk); #1;
        pcm_stb = 1'b1;
        pcm_data = d;
        if (slot == 0)
            for (int i = 0; i < 4; i++) wq.push_back({fill, 10'(14+i), 8'(exp_seq >> (8*(3-i)))});
        for (int i = 0; i < 4; i++) wq.push_back({fill, 10'(18+4*slot+i), 8'(d >> (8*i))});
        slot++;
        if (slot == 2) begin
            slot = 0;
            txq.push_back(fill);
            exp_tx_bank = fill;
            exp_seq++;
        end
        if (ovr) exp_drop++;
        @(posedge clk); #1;
        pcm_stb = 1'b0;
        pcm_data = $urandom;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b1) begin
                errors++;
                $display("FAIL write_timing byte %0d: wr_en=%b required 1", i, wr_en);
            end
            @(posedge clk); #1;
            pcm_stb = ovr && i == 0;
            pcm_data = od;
        end
        pcm_stb = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL write_stop: wr_en=%b required 0", wr_en);
        end
    endtask

    task automatic wait_tx();
        int base;
        int k;
        base = tx_seen;
        k = 0;
        while (tx_seen == base && k < 20) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        checks++;
        if (tx_seen != base + 1) begin
            errors++;
            $display("FAIL tx_count: got %0d tx_start pulses required 1", tx_seen - base);
        end
    endtask

    task automatic drops(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pcm_stb = 1'b1;
            @(posedge clk); #1;
            pcm_stb = 1'b0;
        end
        exp_drop = (exp_drop + n > 65535) ? 65535 : exp_drop + n;
    endtask

    task automatic check_drop(input string name);
        checks++;
        if (drop_count !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL %s: drop_count=%0d required %0d", name, drop_count, exp_drop);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        txq.delete();
        slot = 0;
        exp_drop = 0;
        exp_tx_bank = 1'b0;
        exp_seq = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, tx_start, tx_bank, drop_count} !== '0) begin
            errors++;
            $display("FAIL reset_state: wr_en=%b wr_addr=%h wr_data=%h tx_start=%b tx_bank=%b drop=%h required all 0",
                     wr_en, wr_addr, wr_data, tx_start, tx_bank, drop_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        strobe({16'hABCD, 16'h1234}, 1'b0, '0);
        strobe({16'hFFFF, 16'h0001}, 1'b0, '0);
        wait_tx();
        check_drop("single_frame_drops");
    endtask

    task automatic test_second_frame();
        strobe({16'h8000, 16'h7FFF}, 1'b0, '0);
        strobe({16'h5AA5, 16'hC33C}, 1'b0, '0);
        wait_tx();
        checks++;
        if (tx_bank !== 1'b0) begin
            errors++;
            $display("FAIL second_tx_bank: got %b required 0", tx_bank);
        end
    endtask

    task automatic test_back_pressure();
        int base;
        tx_busy = 1'b1;
        strobe({16'h1111, 16'h2222}, 1'b0, '0);
        strobe({16'h3333, 16'h4444}, 1'b0, '0);
        base = tx_seen;
        drops(3);
        check_drop("backpressure_drops");
        checks++;
        if (tx_seen != base) begin
            errors++;
            $display("FAIL backpressure_tx: got %0d pulses while busy required 0", tx_seen - base);
        end
        @(posedge clk); #1;
        tx_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1) begin
            errors++;
            $display("FAIL release_tx_start: tx_start=%b required 1", tx_start);
        end
        repeat (4) @(posedge clk);
        strobe({16'h0F0F, 16'hF0F0}, 1'b0, '0);
        strobe({16'hDEAD, 16'hBEEF}, 1'b0, '0);
        wait_tx();
    endtask

    task automatic test_overrun();
        strobe({16'h0102, 16'h0304}, 1'b0, '0);
        strobe({16'hCAFE, 16'hBABE}, 1'b1, {16'h9999, 16'h7777});
        check_drop("overrun_drops");
        wait_tx();
    endtask

    task automatic test_reset_mid_frame();
        int base;
        strobe({16'h2468, 16'h1357}, 1'b0, '0);
        @(posedge clk); #1;
        pcm_stb = 1'b1;
        pcm_data = {16'hEEEE, 16'hDDDD};
        @(posedge clk); #1;
        pcm_stb = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, tx_start, tx_bank, drop_count} !== '0) begin
            errors++;
            $display("FAIL midframe_reset: wr_en=%b wr_addr=%h wr_data=%h tx_start=%b tx_bank=%b drop=%h required all 0",
                     wr_en, wr_addr, wr_data, tx_start, tx_bank, drop_count);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        base = tx_seen;
        repeat (10) @(posedge clk);
        checks++;
        if (tx_seen != base) begin
            errors++;
            $display("FAIL midframe_no_tx: got %0d pulses required 0", tx_seen - base);
        end
        strobe({16'h0A0B, 16'h0C0D}, 1'b0, '0);
        strobe({16'h1A1B, 16'h1C1D}, 1'b0, '0);
        wait_tx();
    endtask

    task automatic test_saturation();
        tx_busy = 1'b1;
        strobe({16'h5555, 16'h6666}, 1'b0, '0);
        strobe({16'h7777, 16'h8888}, 1'b0, '0);
        @(posedge clk); #1;
        pcm_stb = 1'b1;
        repeat (65537) @(posedge clk);
        #1;
        pcm_stb = 1'b0;
        exp_drop = 65535;
        check_drop("saturation");
        @(posedge clk); #1;
        rst = 1'b1;
        pcm_stb = 1'b1;
        #1;
        model_reset();
        check_drop("reset_with_strobe");
        @(posedge clk); #1;
        check_drop("reset_with_strobe_held");
        rst = 1'b0;
        pcm_stb = 1'b0;
        tx_busy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_second_frame();
        test_back_pressure();
        test_overrun();
        test_reset_mid_frame();
        test_saturation();
        repeat (5) @(posedge clk);
        checks++;
        if (wq.size() != 0 || txq.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d writes and %0d tx_start pulses still expected, required 0",
                     wq.size(), txq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcm_frame_packer.md
Name: pcm_frame_packer

Overview:
- Sits between the audio_filter bank and the ethernet transmitter (eth_tx2).
- On each PCM strobe, snapshots all channel samples and writes them byte-by-byte into a ping-pong BRAM.
- After SAMPLES strobes, it prefixes the frame with a 32-bit sequence number and hands the filled bank to the transmitter with a start pulse.
- Counts PCM strobes it had to drop because it was busy or blocked.

Parameters:
- NCHAN, 8: PCM channels per strobe, each 16-bit signed.
- SAMPLES, 32: strobes per frame.
- HDR_BYTES, 14: bytes reserved at the start of each bank for the Ethernet header. The packer never writes them.
- OFS_W, 10: byte-offset width within one bank. HDR_BYTES+4+2*NCHAN*SAMPLES must be ≤ 2^OFS_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pcm_stb  in  1  one-cycle strobe; pcm_data is valid in the same cycle
- pcm_data  in  16*NCHAN  channel c occupies bits [16c+15:16c]
- wr_en  out  1  BRAM write enable
- wr_addr  out  OFS_W+1  {bank, byte offset}
- wr_data  out  8  BRAM write byte
- tx_start  out  1  one-cycle pulse: the bank in tx_bank is ready to send
- tx_bank  out  1  bank the transmitter reads; held stable between tx_start pulses
- tx_busy  in  1  transmitter busy
- drop_count  out  16  count of dropped strobes; saturates at 0xFFFF

Behaviour:
- Reset (async, rst=1) clears: wr_en, wr_addr, wr_data, tx_start, tx_bank, drop_count, fill bank, sequence counter, strobe counter; state goes to IDLE.
- Reset mid-frame discards the partial frame. No tx_start is issued for it.
- Fill bank is always ~tx_bank.
- Offset within a bank:
  - Sequence number: HDR_BYTES..HDR_BYTES+3, big-endian.
  - Strobe k, channel c, low byte: HDR_BYTES+4+2*(k*NCHAN+c).
  - High byte is at that offset +1. Samples are little-endian, channel 0 first.
- IDLE:
  - pcm_stb=1 latches all of pcm_data into a snapshot register.
  - If strobe counter == 0, go to SEQ; otherwise go to SAMPLE.
- SEQ: 4 cycles, one sequence byte per cycle, MSB first, wr_en=1. Then go to SAMPLE.
- SAMPLE: 2*NCHAN cycles, one byte per cycle from the snapshot, wr_en=1.
  - The first sample byte write starts 1 cycle after the strobe (5 cycles after when SEQ runs first).
  - After the last byte, increment the strobe counter.
  - If the counter reaches SAMPLES, clear it and go to WAIT_TX; otherwise go to IDLE.
- WAIT_TX: wr_en=0. When tx_busy=0:
  - tx_bank <= fill bank (swap banks).
  - Pulse tx_start for exactly 1 cycle.
  - Increment the 32-bit sequence counter (wraps 0xFFFFFFFF→0).
  - Go to HOLDOFF.
- HOLDOFF: 2 cycles, tx_busy ignored so the transmitter can assert it. Then go to IDLE.
- Drops:
  - pcm_stb in any state other than IDLE is ignored and increments drop_count (saturating).
  - A strobe coinciding with the IDLE exit cycle is the accepted strobe and is not counted.
  - Dropped samples leave no gap in the frame: the next accepted strobe fills the next slot.
- wr_addr and wr_data are don't-care when wr_en=0, but must not glitch into header bytes 0..HDR_BYTES-1 while wr_en=1.
- Simultaneous rst and pcm_stb: reset wins; no drop is counted.

Test Plan (NCHAN=2, SAMPLES=2, HDR_BYTES=14 unless noted):
- Single frame, tx_busy=0:
  - Stimulus: strobe 1 with ch0=0x1234, ch1=0xABCD, then strobe 2 with ch0=0x0001, ch1=0xFFFF.
  - Bank 1 offsets 14..17 = 00 00 00 00.
  - Offsets 18..21 = 34 12 CD AB.
  - Offsets 22..25 = 01 00 FF FF.
  - Exactly one tx_start, with tx_bank=1. No write ever touches offsets 0..13.
- Second frame:
  - Sequence bytes are 00 00 00 01, written to bank 0.
  - tx_bank becomes 0 on the second tx_start.
- Back-pressure:
  - Hold tx_busy=1 when the frame completes, then send 3 strobes: drop_count=3 and no tx_start.
  - Release tx_busy: tx_start occurs on the next cycle, and the next accepted strobe lands at offset 18.
- Overrun: a strobe arriving 2 cycles after an accepted strobe (mid SAMPLE) gives drop_count +1, and the snapshot data is unchanged.
- Reset mid-frame:
  - Assert rst after 1 strobe: all outputs are 0 within the same cycle, no tx_start ever follows, and the next frame goes to bank 1 with sequence 0.
- Saturation: force 65537 drops → drop_count=0xFFFF.
